mw93_frontend: RTL and testbench

//   Microwire (93xx serial EEPROM) slave front end. Oversamples CS/SK/DI on the system clock and

---
 rtl/mw93_pkg.sv | 29 ++
 rtl/mw93_pin_sync.sv | 40 ++++
 rtl/mw93_frontend.sv | 182 ++++++++++++++++++
 tb/tb_mw93_frontend.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw93_pkg.sv
// Shared opcodes, request encodings and FSM state type for the 93xx Microwire front end.
package mw93_pkg;

    localparam logic [1:0] OPC_EXT   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_ERASE = 2'b11;

    // Extended codes live in the top two address bits when the opcode is 00.
    localparam logic [1:0] EXT_EWDS = 2'b00;
    localparam logic [1:0] EXT_WRAL = 2'b01;
    localparam logic [1:0] EXT_ERAL = 2'b10;
    localparam logic [1:0] EXT_EWEN = 2'b11;

    localparam logic [2:0] REQ_RD   = 3'd0;
    localparam logic [2:0] REQ_WR   = 3'd1;
    localparam logic [2:0] REQ_ER   = 3'd2;
    localparam logic [2:0] REQ_ERAL = 3'd3;
    localparam logic [2:0] REQ_WRAL = 3'd4;
    // Internal-only op codes: never presented on req_op.
    localparam logic [2:0] OP_EWEN  = 3'd5;
    localparam logic [2:0] OP_EWDS  = 3'd6;

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_OPC, ST_ADDR, ST_DATA,
        ST_DONE, ST_ISSUE, ST_RDWAIT, ST_RDOUT, ST_STATUS
    } state_t;

endpackage

// File: rtl/mw93_pin_sync.sv
// Synchronises the asynchronous Microwire pins and derives SK rising / CS falling strobes.
module mw93_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sk,
    input  logic di,
    output logic cs_s,
    output logic di_s,
    output logic sk_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] cs_q, sk_q, di_q;
    logic                   cs_d, sk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q <= '0;
            sk_q <= '0;
            di_q <= '0;
            cs_d <= 1'b0;
            sk_d <= 1'b0;
        end else begin
            cs_q <= {cs_q[SYNC_STAGES-2:0], cs};
            sk_q <= {sk_q[SYNC_STAGES-2:0], sk};
            di_q <= {di_q[SYNC_STAGES-2:0], di};
            cs_d <= cs_q[SYNC_STAGES-1];
            sk_d <= sk_q[SYNC_STAGES-1];
        end
    end

    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign di_s    = di_q[SYNC_STAGES-1];
    assign sk_rise = sk_q[SYNC_STAGES-1] & ~sk_d;
    assign cs_fall = ~cs_q[SYNC_STAGES-1] & cs_d;

endmodule

// File: rtl/mw93_frontend.sv
// Microwire slave front end: decodes 93xx frames into storage requests and drives read data
// and ready/busy status back onto DO.
module mw93_frontend
    import mw93_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mw_cs,
    input  logic              mw_sk,
    input  logic              mw_di,
    output logic              mw_do,
    output logic              mw_do_oe,
    output logic              req_valid,
    output logic [2:0]        req_op,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              busy
);

    logic cs_s, di_s, sk_rise, cs_fall;

    mw93_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .cs      (mw_cs),
        .sk      (mw_sk),
        .di      (mw_di),
        .cs_s    (cs_s),
        .di_s    (di_s),
        .sk_rise (sk_rise),
        .cs_fall (cs_fall)
    );

    state_t              state, state_n;
    logic [7:0]          cnt, cnt_n;
    logic [1:0]          opc, opc_n;
    logic [ADDR_W-1:0]   addr, addr_n, addr_shift;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [2:0]          op, op_n;
    logic                do_q, do_n, wen, wen_n, armed, armed_n;

    assign addr_shift = {addr[ADDR_W-2:0], di_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            opc   <= '0;
            addr  <= '0;
            shreg <= '0;
            op    <= REQ_RD;
            do_q  <= 1'b0;
            wen   <= 1'b0;
            armed <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            opc   <= opc_n;
            addr  <= addr_n;
            shreg <= shreg_n;
            op    <= op_n;
            do_q  <= do_n;
            wen   <= wen_n;
            armed <= armed_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        opc_n   = opc;
        addr_n  = addr;
        shreg_n = shreg;
        op_n    = op;
        do_n    = do_q;
        wen_n   = wen;
        armed_n = armed;
        if (state == ST_ISSUE) begin
            // An issued request is never abandoned, even if CS drops meanwhile.
            if (req_ready) begin
                if (op == REQ_RD && cs_s) begin
                    state_n = ST_RDWAIT;
                end else begin
                    state_n = ST_IDLE;
                    if (op != REQ_RD) armed_n = 1'b1;
                end
            end
        end else if (!cs_s) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            do_n    = 1'b0;
            if (cs_fall && state == ST_STATUS) armed_n = 1'b0;
            if (cs_fall && state == ST_DONE) begin
                if (op == OP_EWEN)          wen_n   = 1'b1;
                else if (op == OP_EWDS)     wen_n   = 1'b0;
                else if (wen && !busy)      state_n = ST_ISSUE;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_n   = '0;
                    state_n = armed ? ST_STATUS : ST_START;
                end
                ST_START: if (sk_rise && di_s) begin
                    cnt_n   = '0;
                    state_n = ST_OPC;
                end
                ST_OPC: if (sk_rise) begin
                    opc_n = {opc[0], di_s};
                    if (cnt == 8'd1) begin
                        cnt_n   = '0;
                        state_n = ST_ADDR;
                    end else cnt_n = cnt + 8'd1;
                end
                ST_ADDR: if (sk_rise) begin
                    addr_n = addr_shift;
                    if (cnt == 8'(ADDR_W-1)) begin
                        cnt_n = '0;
                        case (opc)
                            OPC_READ: begin
                                op_n = REQ_RD; do_n = 1'b0; state_n = ST_ISSUE;
                            end
                            OPC_WRITE: begin op_n = REQ_WR; state_n = ST_DATA; end
                            OPC_EXT: begin
                                case (addr_shift[ADDR_W-1 -: 2])
                                    EXT_EWEN: begin op_n = OP_EWEN;  state_n = ST_DONE; end
                                    EXT_EWDS: begin op_n = OP_EWDS;  state_n = ST_DONE; end
                                    EXT_ERAL: begin op_n = REQ_ERAL; state_n = ST_DONE; end
                                    default:  begin op_n = REQ_WRAL; state_n = ST_DATA; end
                                endcase
                            end
                            default: begin op_n = REQ_ER; state_n = ST_DONE; end
                        endcase
                    end else cnt_n = cnt + 8'd1;
                end
                ST_DATA: if (sk_rise) begin
                    shreg_n = {shreg[DATA_W-2:0], di_s};
                    if (cnt == 8'(DATA_W-1)) begin
                        cnt_n   = '0;
                        state_n = ST_DONE;
                    end else cnt_n = cnt + 8'd1;
                end
                ST_RDWAIT: if (rd_valid) begin
                    shreg_n = rd_data;
                    cnt_n   = '0;
                    state_n = ST_RDOUT;
                end
                ST_RDOUT: if (sk_rise) begin
                    do_n    = shreg[DATA_W-1];
                    shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    // Sequential read: after the last bit the next word is fetched automatically.
                    if (cnt == 8'(DATA_W-1)) begin
                        cnt_n   = '0;
                        addr_n  = addr + ADDR_W'(1);
                        op_n    = REQ_RD;
                        state_n = ST_ISSUE;
                    end else cnt_n = cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake: req_valid rises with op/addr/wdata stable and holds them unchanged until the
    // cycle where req_ready is also high; that cycle is the transfer.
    assign req_valid = (state == ST_ISSUE);
    assign req_op    = req_valid ? op : 3'd0;
    assign req_addr  = req_valid ? addr : '0;
    assign req_wdata = (req_valid && (op == REQ_WR || op == REQ_WRAL)) ? shreg : '0;

    assign mw_do_oe = cs_s && (state == ST_RDWAIT || state == ST_RDOUT || state == ST_STATUS ||
                               (state == ST_ISSUE && op == REQ_RD));
    assign mw_do    = mw_do_oe && ((state == ST_STATUS) ? ~busy : do_q);

endmodule

// File: tb/tb_mw93_frontend.sv
// Self-checking bench for mw93_frontend: randomized Microwire frames against a frame-level model.
module tb_mw93_frontend;

    localparam int SYNC_STAGES = 2;
    localparam logic [2:0] RD = 3'd0, WR = 3'd1, ER = 3'd2, ERAL = 3'd3, WRAL = 3'd4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mw_cs = 1'b0, mw_sk = 1'b0, mw_di = 1'b0;
    logic        mw_do, mw_do_oe, req_valid;
    logic [2:0]  req_op;
    logic [5:0]  req_addr;
    logic [15:0] req_wdata;
    logic        req_ready, rd_valid, busy = 1'b0;
    logic [15:0] rd_data;

    always #5 clk = ~clk;

    mw93_frontend #(.ADDR_W(6), .DATA_W(16), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .mw_cs(mw_cs), .mw_sk(mw_sk), .mw_di(mw_di),
        .mw_do(mw_do), .mw_do_oe(mw_do_oe), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    logic [15:0] mem [64];
    logic [24:0] exp_q[$];
    logic [24:0] act_q[$];
    int          n_checks = 0, n_pass = 0;
    logic        ref_wen = 1'b0;
    logic        stalled = 1'b0;
    int          rd_wait = 0;
    logic [5:0]  rd_addr = '0;
    logic        last_do, last_oe, addr_do, addr_oe;
    logic [63:0] do_bits, exp_bits;
    logic        accepted;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Storage responder: at most one stall cycle, read data two cycles after acceptance.
    initial begin
        req_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #2;
            rd_valid = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin rd_valid = 1'b1; rd_data = mem[rd_addr]; end
            end
            req_ready = stalled || ($urandom_range(0, 1) == 1);
            stalled   = req_valid && !req_ready;
            if (req_valid && req_ready) begin
                act_q.push_back({req_op, req_addr, req_wdata});
                if (req_op == RD) begin rd_wait = 2; rd_addr = req_addr; end
            end
        end
    end

    task automatic sk_cycle(input logic b);
        mw_di = b; tick(4);
        mw_sk = 1'b1; tick(4);
        last_do = mw_do; last_oe = mw_do_oe;
        mw_sk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sk_cycle(v[i]);
    endtask

    task automatic drive_frame(input logic [1:0] opc, input logic [5:0] a, input logic [15:0] d,
                               input int data_sks, input int rd_sks);
        mw_cs = 1'b1; tick(4);
        send_bits({23'b0, 1'b1, opc, a}, 9);
        addr_do = last_do; addr_oe = last_oe;
        if (data_sks > 0) send_bits({16'b0, d}, 16);
        do_bits = '0;
        for (int j = 0; j < rd_sks; j++) begin
            sk_cycle(1'b0);
            do_bits = {do_bits[62:0], last_do};
        end
        mw_cs = 1'b0; mw_di = 1'b0; tick(6);
        for (int i = 0; i < 40 && req_valid; i++) tick(1);
        tick(2);
        n_checks++;
        if (req_valid !== 1'b0) $display("FAIL handshake_timeout: req_valid=%b required 0", req_valid);
        else n_pass++;
    endtask

    task automatic status_poll();
        mw_cs = 1'b1; tick(6);
        mw_cs = 1'b0; tick(6);
    endtask

    // Frame-level reference: which requests a frame yields and the DO bits after the dummy bit.
    task automatic model_frame(input logic [1:0] opc, input logic [5:0] a, input logic [15:0] d,
                               input int rd_sks, input logic busy_now);
        logic ok;
        ok = ref_wen && !busy_now;
        accepted = 1'b0; exp_bits = '0;
        case (opc)
            2'b10: begin
                for (int i = 0; i <= rd_sks / 16; i++) exp_q.push_back({RD, 6'(a + i), 16'h0});
                for (int j = 1; j <= rd_sks; j++)
                    exp_bits = {exp_bits[62:0], mem[6'(a + (j - 1) / 16)][15 - ((j - 1) % 16)]};
            end
            2'b01: if (ok) begin exp_q.push_back({WR, a, d}); accepted = 1'b1; end
            2'b11: if (ok) begin exp_q.push_back({ER, a, 16'h0}); accepted = 1'b1; end
            default: case (a[5:4])
                2'b11: ref_wen = 1'b1;
                2'b00: ref_wen = 1'b0;
                2'b10: if (ok) begin exp_q.push_back({ERAL, a, 16'h0}); accepted = 1'b1; end
                default: if (ok) begin exp_q.push_back({WRAL, a, d}); accepted = 1'b1; end
            endcase
        endcase
    endtask

    function automatic bit q_match();
        if (act_q.size() != exp_q.size()) return 1'b0;
        foreach (act_q[i]) if (act_q[i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_qs();
        exp_q.delete(); act_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(3);
        n_checks++;
        if ({mw_do, mw_do_oe, req_valid, req_op, req_addr, req_wdata} !== 28'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {mw_do, mw_do_oe, req_valid, req_op, req_addr, req_wdata});
        else n_pass++;
        rst = 1'b0; tick(2);
    endtask

    task automatic test_read();
        logic [5:0] a;
        for (int k = 0; k < 5; k++) begin
            a = (k == 0) ? 6'h05 : 6'($urandom_range(0, 63));
            if (k == 0) mem[5] = 16'hA5C3;
            clear_qs();
            model_frame(2'b10, a, 16'h0, 16, 1'b0);
            drive_frame(2'b10, a, 16'h0, 0, 16);
            n_checks++;
            if (addr_oe !== 1'b1 || addr_do !== 1'b0)
                $display("FAIL read_dummy: oe=%b do=%b required oe=1 do=0", addr_oe, addr_do);
            else n_pass++;
            n_checks++;
            if (do_bits[15:0] !== exp_bits[15:0])
                $display("FAIL read_data: addr %h got %h required %h", a, do_bits[15:0], exp_bits[15:0]);
            else n_pass++;
            n_checks++;
            if (!q_match()) $display("FAIL read_reqs: got %0d reqs (first %h) required %0d (first %h)",
                                     act_q.size(), act_q.size() ? act_q[0] : 25'h0,
                                     exp_q.size(), exp_q[0]);
            else n_pass++;
        end
    endtask

    task automatic test_write_wen();
        clear_qs();
        model_frame(2'b00, 6'h00, 16'h0, 0, 1'b0); drive_frame(2'b00, 6'h00, 16'h0, 0, 0);
        model_frame(2'b01, 6'h3F, 16'h1234, 0, 1'b0); drive_frame(2'b01, 6'h3F, 16'h1234, 16, 0);
        n_checks++;
        if (act_q.size() != 0) $display("FAIL write_wen0: got %0d reqs required 0", act_q.size());
        else n_pass++;
        model_frame(2'b00, 6'h30, 16'h0, 0, 1'b0); drive_frame(2'b00, 6'h30, 16'h0, 0, 0);
        model_frame(2'b01, 6'h3F, 16'h1234, 0, 1'b0); drive_frame(2'b01, 6'h3F, 16'h1234, 16, 0);
        n_checks++;
        if (!q_match() || exp_q.size() != 1)
            $display("FAIL write_wen1: got %0d reqs (first %h) required 1 (%h)",
                     act_q.size(), act_q.size() ? act_q[0] : 25'h0, {WR, 6'h3F, 16'h1234});
        else n_pass++;
        if (accepted) status_poll();
    endtask

    task automatic test_abort();
        logic [5:0] a;
        clear_qs();
        mw_cs = 1'b1; tick(4);
        send_bits({26'b0, 1'b1, 2'b11, 3'b101}, 6);
        mw_cs = 1'b0; mw_di = 1'b0; tick(10);
        n_checks++;
        if (act_q.size() != 0) $display("FAIL abort_erase: got %0d reqs required 0", act_q.size());
        else n_pass++;
        // Aborted EWDS must leave the write enable set.
        mw_cs = 1'b1; tick(4);
        send_bits({27'b0, 1'b1, 2'b00, 2'b00}, 5);
        mw_cs = 1'b0; mw_di = 1'b0; tick(10);
        a = 6'($urandom_range(0, 63));
        clear_qs();
        model_frame(2'b11, a, 16'h0, 0, 1'b0); drive_frame(2'b11, a, 16'h0, 0, 0);
        n_checks++;
        if (!q_match()) $display("FAIL abort_keeps_wen: got %0d reqs required %0d", act_q.size(), exp_q.size());
        else n_pass++;
        if (accepted) status_poll();
        a = 6'($urandom_range(0, 63));
        clear_qs();
        model_frame(2'b10, a, 16'h0, 16, 1'b0); drive_frame(2'b10, a, 16'h0, 0, 16);
        n_checks++;
        if (do_bits[15:0] !== exp_bits[15:0] || !q_match())
            $display("FAIL abort_then_read: data %h required %h, %0d reqs required %0d",
                     do_bits[15:0], exp_bits[15:0], act_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_seq_read();
        clear_qs();
        model_frame(2'b10, 6'h3F, 16'h0, 33, 1'b0);
        drive_frame(2'b10, 6'h3F, 16'h0, 0, 33);
        n_checks++;
        if (do_bits[32:0] !== exp_bits[32:0])
            $display("FAIL seq_data: got %h required %h", do_bits[32:0], exp_bits[32:0]);
        else n_pass++;
        n_checks++;
        if (act_q.size() < 2 || act_q[0][21:16] !== 6'h3F || act_q[1][21:16] !== 6'h00)
            $display("FAIL seq_wrap: %0d reqs, first addrs %h %h required 3f 00", act_q.size(),
                     act_q.size() > 0 ? act_q[0][21:16] : 6'h0, act_q.size() > 1 ? act_q[1][21:16] : 6'h0);
        else n_pass++;
        n_checks++;
        if (!q_match()) $display("FAIL seq_reqs: got %0d reqs required %0d", act_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_busy_drop();
        logic [5:0]  a;
        logic [15:0] d;
        a = 6'($urandom_range(0, 63)); d = 16'($urandom);
        clear_qs();
        busy = 1'b1;
        model_frame(2'b01, a, d, 0, 1'b1); drive_frame(2'b01, a, d, 16, 0);
        busy = 1'b0; tick(2);
        n_checks++;
        if (act_q.size() != 0) $display("FAIL busy_drop: got %0d reqs required 0", act_q.size());
        else n_pass++;
    endtask

    task automatic test_status();
        logic [5:0]  a;
        logic [15:0] d;
        int          waited;
        a = {2'b01, 4'($urandom_range(0, 15))}; d = 16'($urandom);
        clear_qs();
        model_frame(2'b00, a, d, 0, 1'b0); drive_frame(2'b00, a, d, 16, 0);
        n_checks++;
        if (!q_match()) $display("FAIL wral_req: got %0d reqs (first %h) required %h",
                                 act_q.size(), act_q.size() ? act_q[0] : 25'h0, {WRAL, a, d});
        else n_pass++;
        busy = 1'b1; tick(10);
        mw_cs = 1'b1; tick(5);
        n_checks++;
        if (mw_do_oe !== 1'b1 || mw_do !== 1'b0)
            $display("FAIL status_busy: oe=%b do=%b required oe=1 do=0", mw_do_oe, mw_do);
        else n_pass++;
        tick(35);
        busy = 1'b0;
        waited = 0;
        while (waited < SYNC_STAGES + 2 && mw_do !== 1'b1) begin tick(1); waited++; end
        n_checks++;
        if (mw_do_oe !== 1'b1 || mw_do !== 1'b1)
            $display("FAIL status_ready: oe=%b do=%b after %0d clk required oe=1 do=1", mw_do_oe, mw_do, waited);
        else n_pass++;
        mw_cs = 1'b0; tick(6);
    endtask

    task automatic test_random();
        logic [1:0]  opc;
        logic [5:0]  a;
        logic [15:0] d;
        logic        bz;
        int          dsk, rsk;
        for (int k = 0; k < 10; k++) begin
            opc = 2'($urandom_range(0, 3));
            a   = 6'($urandom_range(0, 63));
            d   = 16'($urandom);
            bz  = (opc != 2'b10) && ($urandom_range(0, 3) == 0);
            dsk = (opc == 2'b01 || (opc == 2'b00 && a[5:4] == 2'b01)) ? 16 : 0;
            rsk = (opc == 2'b10) ? 16 : 0;
            clear_qs();
            model_frame(opc, a, d, rsk, bz);
            busy = bz;
            drive_frame(opc, a, d, dsk, rsk);
            busy = 1'b0;
            n_checks++;
            if (!q_match() || do_bits[15:0] !== exp_bits[15:0])
                $display("FAIL rand_frame: opc %b addr %h: %0d reqs required %0d, data %h required %h",
                         opc, a, act_q.size(), exp_q.size(), do_bits[15:0], exp_bits[15:0]);
            else n_pass++;
            if (accepted) status_poll();
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0]  a;
        logic [15:0] d;
        ref_wen = 1'b1;
        model_frame(2'b00, 6'h3C, 16'h0, 0, 1'b0); drive_frame(2'b00, 6'h3C, 16'h0, 0, 0);
        a = 6'($urandom_range(0, 63));
        mw_cs = 1'b1; tick(4);
        send_bits({23'b0, 1'b1, 2'b10, a}, 9);
        for (int j = 0; j < 5; j++) sk_cycle(1'b0);
        rst = 1'b1; tick(1);
        n_checks++;
        if ({mw_do, mw_do_oe, req_valid, req_op, req_addr, req_wdata} !== 28'h0)
            $display("FAIL rst_mid_outputs: got %h required 0",
                     {mw_do, mw_do_oe, req_valid, req_op, req_addr, req_wdata});
        else n_pass++;
        mw_cs = 1'b0; mw_sk = 1'b0; mw_di = 1'b0; tick(2);
        rst = 1'b0; ref_wen = 1'b0; tick(6);
        clear_qs();
        a = 6'($urandom_range(0, 63)); d = 16'($urandom);
        model_frame(2'b01, a, d, 0, 1'b0); drive_frame(2'b01, a, d, 16, 0);
        n_checks++;
        if (act_q.size() != 0) $display("FAIL rst_clears_wen: got %0d reqs required 0", act_q.size());
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        test_reset();
        test_read();
        test_write_wen();
        test_abort();
        test_seq_read();
        test_busy_drop();
        test_status();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
